wdt_ctrl: RTL

WDT_CTRL -- requirements
Module: wdt_ctrl

---
 rtl/wdt_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/wdt_ctrl.sv
// wdt_ctrl -- control front-end for an external watchdog counter.
//
// Software programs a timeout threshold and an optional early-kick window,
// then enables the watchdog. While running, software must periodically
// write the kick key. A bark from the downstream counter raises an
// early-warning interrupt and starts a grace period; if the grace period
// expires, or software kicks with a wrong key or too early, the block
// "bites": it pulses sys_rst_o for RST_PULSE_LEN cycles and records why.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_i          asynchronous active-high reset
//   cfg_we_i       config write strobe (one write per cycle)
//   cfg_addr_i     0=CTRL (bit0 enable, bit1 lock), 1=TIMEOUT, 2=WINDOW, 3=KICK
//   cfg_wdata_i    write data
//   wdt_bark_i     timeout flag from the downstream watchdog counter
//   wdt_kick_o     clear strobe to the watchdog counter
//   wdt_timeout_o  threshold to the watchdog counter
//   irq_o          early-warning interrupt (level)
//   sys_rst_o      system reset pulse, active-high
//   state_o        FSM state: IDLE=0, RUN=1, WARN=2, BITE=3
//   cause_o        last bite cause: 0=none, 1=timeout, 2=early kick, 3=bad key
//
// Config handshake: cfg_we_i is a single-cycle strobe with no back-pressure;
// a write is sampled on the rising edge where cfg_we_i=1 and either takes
// effect or is silently dropped (lock set, wrong state, or BITE).
//
// All outputs are registers; nothing passes combinationally from an input
// to an output.
module wdt_ctrl #(
    parameter logic [31:0] KICK_KEY      = 32'h5A5A_C3C3,
    parameter logic [15:0] GRACE_CYCLES  = 16'd256,
    parameter logic [7:0]  RST_PULSE_LEN = 8'd16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_we_i,
    input  logic [1:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    input  logic        wdt_bark_i,
    output logic        wdt_kick_o,
    output logic [31:0] wdt_timeout_o,
    output logic        irq_o,
    output logic        sys_rst_o,
    output logic [1:0]  state_o,
    output logic [1:0]  cause_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WARN = 2'd2,
        ST_BITE = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd1;
    localparam logic [1:0] ADDR_WINDOW  = 2'd2;
    localparam logic [1:0] ADDR_KICK    = 2'd3;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd1;
    localparam logic [1:0] CAUSE_EARLY   = 2'd2;
    localparam logic [1:0] CAUSE_BADKEY  = 2'd3;

    localparam logic [31:0] ELAPSED_MAX = 32'hFFFF_FFFF;

    state_t      state;
    logic        enable;
    logic        lock;
    logic [31:0] timeout_q;
    logic [31:0] window_q;
    logic [31:0] elapsed;
    logic [15:0] grace;
    logic [7:0]  pulse;

    logic        active;
    logic        ctrl_wr;
    logic        ctrl_off;
    logic        kick_wr;
    logic        key_ok;
    logic        kick_early;
    logic        bite_go;
    logic [1:0]  bite_cause;
    logic [31:0] elapsed_inc;

    assign wdt_timeout_o = timeout_q;
    assign state_o       = state;

    // Decode of the current cycle's write and the bite decision. A window of
    // zero never flags an early kick because elapsed is never below zero.
    always_comb begin
        active      = enable && ((state == ST_RUN) || (state == ST_WARN));
        ctrl_wr     = cfg_we_i && (cfg_addr_i == ADDR_CTRL) && !lock;
        ctrl_off    = ctrl_wr && !cfg_wdata_i[0];
        kick_wr     = cfg_we_i && (cfg_addr_i == ADDR_KICK);
        key_ok      = (cfg_wdata_i == KICK_KEY);
        kick_early  = (elapsed < window_q);
        elapsed_inc = (elapsed == ELAPSED_MAX) ? ELAPSED_MAX : (elapsed + 32'd1);

        bite_go    = 1'b0;
        bite_cause = CAUSE_NONE;
        if (active && !ctrl_off) begin
            // A kick error always names the cause, even if bark or grace
            // expiry happen in the same cycle.
            if (kick_wr) begin
                if (!key_ok) begin
                    bite_go    = 1'b1;
                    bite_cause = CAUSE_BADKEY;
                end else if (kick_early) begin
                    bite_go    = 1'b1;
                    bite_cause = CAUSE_EARLY;
                end
            end else if ((state == ST_WARN) && (grace == 16'd0)) begin
                bite_go    = 1'b1;
                bite_cause = CAUSE_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            enable     <= 1'b0;
            lock       <= 1'b0;
            timeout_q  <= 32'hFFFF_FFFF;
            window_q   <= 32'd0;
            elapsed    <= 32'd0;
            grace      <= 16'd0;
            pulse      <= 8'd0;
            wdt_kick_o <= 1'b1;
            irq_o      <= 1'b0;
            sys_rst_o  <= 1'b0;
            cause_o    <= CAUSE_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Counter is held cleared while disabled.
                    elapsed    <= 32'd0;
                    wdt_kick_o <= 1'b1;
                    if (cfg_we_i && !lock) begin
                        case (cfg_addr_i)
                            ADDR_TIMEOUT: timeout_q <= cfg_wdata_i;
                            ADDR_WINDOW:  window_q  <= cfg_wdata_i;
                            ADDR_CTRL: begin
                                lock <= lock | cfg_wdata_i[1];
                                if (cfg_wdata_i[0]) begin
                                    enable     <= 1'b1;
                                    state      <= ST_RUN;
                                    wdt_kick_o <= 1'b0;
                                end
                            end
                            default: ; // KICK ignored while idle
                        endcase
                    end
                end

                ST_RUN, ST_WARN: begin
                    elapsed    <= elapsed_inc;
                    wdt_kick_o <= 1'b0;
                    if (ctrl_off) begin
                        lock       <= lock | cfg_wdata_i[1];
                        enable     <= 1'b0;
                        irq_o      <= 1'b0;
                        state      <= ST_IDLE;
                        wdt_kick_o <= 1'b1;
                        elapsed    <= 32'd0;
                    end else begin
                        if (ctrl_wr) begin
                            lock <= lock | cfg_wdata_i[1];
                        end
                        if (bite_go) begin
                            state      <= ST_BITE;
                            sys_rst_o  <= 1'b1;
                            wdt_kick_o <= 1'b1;
                            cause_o    <= bite_cause;
                            pulse      <= RST_PULSE_LEN - 8'd1;
                        end else if (kick_wr) begin
                            // Valid kick: beats any simultaneous bark or expiry.
                            wdt_kick_o <= 1'b1;
                            elapsed    <= 32'd0;
                            irq_o      <= 1'b0;
                            state      <= ST_RUN;
                        end else if ((state == ST_RUN) && wdt_bark_i) begin
                            state <= ST_WARN;
                            irq_o <= 1'b1;
                            grace <= GRACE_CYCLES - 16'd1;
                        end else if (state == ST_WARN) begin
                            grace <= grace - 16'd1;
                        end
                    end
                end

                ST_BITE: begin
                    sys_rst_o  <= 1'b1;
                    wdt_kick_o <= 1'b1;
                    if (pulse == 8'd0) begin
                        state     <= ST_IDLE;
                        sys_rst_o <= 1'b0;
                        enable    <= 1'b0;
                        irq_o     <= 1'b0;
                        elapsed   <= 32'd0;
                    end else begin
                        pulse <= pulse - 8'd1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
